// File: rtl/permutation.sv
// One ASCON round per clock: constant addition, bitsliced S-box and linear
// diffusion over the 320-bit state, with the result captured in the state register.
package ascon_pack;
   typedef logic [4:0][63:0] type_state;
endpackage

module permutation
   import ascon_pack::*;
(
   input  logic        clock_i,
   input  logic        resetb_i,
   input  logic        select_i,
   input  type_state   permutation_i,
   input  logic [3:0]  round_i,
   input  logic        enable_i,
   output type_state   permutation_o
);

   type_state state_q, state_d;
   type_state op_s, pc_s, ps_s, pl_s;
   type_state sx_s, st_s;
   logic [7:0] const_s;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   assign op_s = select_i ? permutation_i : state_q;

   // Upper nibble of the round constant is 15 - r, which is simply ~r.
   assign const_s = {~round_i, round_i};

   always_comb begin
      pc_s = op_s;
      pc_s[2][7:0] = op_s[2][7:0] ^ const_s;
   end

   always_comb begin
      sx_s = pc_s;
      st_s = '0;
      sx_s[0] = sx_s[0] ^ sx_s[4];
      sx_s[4] = sx_s[4] ^ sx_s[3];
      sx_s[2] = sx_s[2] ^ sx_s[1];
      for (int i = 0; i < 5; i++) begin
         st_s[i] = ~sx_s[i] & sx_s[(i + 1) % 5];
      end
      for (int i = 0; i < 5; i++) begin
         sx_s[i] = sx_s[i] ^ st_s[(i + 1) % 5];
      end
      sx_s[1] = sx_s[1] ^ sx_s[0];
      sx_s[0] = sx_s[0] ^ sx_s[4];
      sx_s[3] = sx_s[3] ^ sx_s[2];
      sx_s[2] = ~sx_s[2];
      ps_s = sx_s;
   end

   always_comb begin
      pl_s[0] = ps_s[0] ^ rotr(ps_s[0], 19) ^ rotr(ps_s[0], 28);
      pl_s[1] = ps_s[1] ^ rotr(ps_s[1], 61) ^ rotr(ps_s[1], 39);
      pl_s[2] = ps_s[2] ^ rotr(ps_s[2], 1)  ^ rotr(ps_s[2], 6);
      pl_s[3] = ps_s[3] ^ rotr(ps_s[3], 10) ^ rotr(ps_s[3], 17);
      pl_s[4] = ps_s[4] ^ rotr(ps_s[4], 7)  ^ rotr(ps_s[4], 41);
   end

   assign state_d = enable_i ? pl_s : state_q;

   always_ff @(posedge clock_i or posedge resetb_i) begin
      if (resetb_i) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign permutation_o = state_q;

endmodule

// File: tb/tb_permutation.sv
// Directed bench for the ASCON round: table-driven S-box reference model plus
// hand-derived vectors for the zero-state round and the reset behaviour.
module tb_permutation;
   import ascon_pack::*;

   logic       clock_i = 1'b0;
   logic       resetb_i;
   logic       select_i;
   type_state  permutation_i;
   logic [3:0] round_i;
   logic       enable_i;
   type_state  permutation_o;

   int total = 0;
   int bad = 0;

   type_state iv_s;
   type_state exp_s;
   type_state p12_s;

   logic [4:0] sbox [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

   permutation dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .select_i      (select_i),
      .permutation_i (permutation_i),
      .round_i       (round_i),
      .enable_i      (enable_i),
      .permutation_o (permutation_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   function automatic type_state round_model(input type_state s, input logic [3:0] r);
      type_state a;
      logic [4:0] v;
      logic [4:0] o;
      logic [7:0] c;
      a = s;
      c = {4'd15 - r, r};
      a[2][7:0] = a[2][7:0] ^ c;
      for (int b = 0; b < 64; b++) begin
         v = {a[0][b], a[1][b], a[2][b], a[3][b], a[4][b]};
         o = sbox[v];
         a[0][b] = o[4];
         a[1][b] = o[3];
         a[2][b] = o[2];
         a[3][b] = o[1];
         a[4][b] = o[0];
      end
      a[0] = a[0] ^ ror(a[0], 19) ^ ror(a[0], 28);
      a[1] = a[1] ^ ror(a[1], 61) ^ ror(a[1], 39);
      a[2] = a[2] ^ ror(a[2], 1)  ^ ror(a[2], 6);
      a[3] = a[3] ^ ror(a[3], 10) ^ ror(a[3], 17);
      a[4] = a[4] ^ ror(a[4], 7)  ^ ror(a[4], 41);
      return a;
   endfunction

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic test_reset();
      resetb_i = 1'b1;
      select_i = 1'b1;
      enable_i = 1'b1;
      round_i = 4'd3;
      permutation_i = {64'hDEADBEEF01234567, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF,
                       64'h123456789ABCDEF0, 64'hCAFEBABE55AA55AA};
      #2;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (permutation_o !== '0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got %h want 0", i, permutation_o);
         end
         select_i = ~select_i;
         round_i = round_i + 4'd5;
         step();
      end
      resetb_i = 1'b0;
      enable_i = 1'b0;
      step();
   endtask

   task automatic test_zero_round();
      type_state hand;
      hand[0] = 64'h001E0F00000000F0;
      hand[1] = 64'h00000001E0000770;
      hand[2] = 64'h3FFFFFFFFFFFFF74;
      hand[3] = 64'h3C780000000000F0;
      hand[4] = 64'h0000000000000000;
      permutation_i = '0;
      select_i = 1'b1;
      round_i = 4'd0;
      enable_i = 1'b1;
      step();
      enable_i = 1'b0;
      total++;
      if (permutation_o !== hand) begin
         bad++;
         $display("FAIL zero_round_hand: got %h want %h", permutation_o, hand);
      end
      total++;
      if (permutation_o !== round_model('0, 4'd0)) begin
         bad++;
         $display("FAIL zero_round_model: got %h want %h", permutation_o, round_model('0, 4'd0));
      end
   endtask

   task automatic test_p12();
      exp_s = iv_s;
      enable_i = 1'b1;
      for (int r = 0; r < 12; r++) begin
         select_i = (r == 0);
         permutation_i = (r == 0) ? iv_s : ~iv_s;
         round_i = 4'(r);
         exp_s = round_model(exp_s, 4'(r));
         step();
         total++;
         if (permutation_o !== exp_s) begin
            bad++;
            $display("FAIL p12_round[%0d]: got %h want %h", r, permutation_o, exp_s);
         end
      end
      p12_s = exp_s;
   endtask

   task automatic test_hold();
      enable_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         select_i = i[0];
         round_i = 4'(i * 3 + 1);
         permutation_i = {5{64'(i) * 64'h0101010101010101}};
         step();
         total++;
         if (permutation_o !== p12_s) begin
            bad++;
            $display("FAIL hold[%0d]: got %h want %h", i, permutation_o, p12_s);
         end
      end
   endtask

   task automatic test_const_sweep();
      permutation_i = '0;
      select_i = 1'b1;
      enable_i = 1'b1;
      for (int r = 0; r < 16; r++) begin
         round_i = 4'(r);
         exp_s = round_model('0, 4'(r));
         step();
         total++;
         if (permutation_o !== exp_s) begin
            bad++;
            $display("FAIL const_sweep[r=%0d]: got %h want %h", r, permutation_o, exp_s);
         end
      end
      enable_i = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_s = iv_s;
      enable_i = 1'b1;
      for (int r = 0; r < 5; r++) begin
         select_i = (r == 0);
         permutation_i = iv_s;
         round_i = 4'(r);
         exp_s = round_model(exp_s, 4'(r));
         step();
      end
      total++;
      if (permutation_o !== exp_s) begin
         bad++;
         $display("FAIL pre_reset_round4: got %h want %h", permutation_o, exp_s);
      end
      select_i = 1'b0;
      round_i = 4'd5;
      #2;
      resetb_i = 1'b1;
      #1;
      total++;
      if (permutation_o !== '0) begin
         bad++;
         $display("FAIL async_reset_immediate: got %h want 0", permutation_o);
      end
      step();
      resetb_i = 1'b0;
      step();
      total++;
      if (permutation_o !== round_model('0, 4'd5)) begin
         bad++;
         $display("FAIL post_reset_from_zero: got %h want %h", permutation_o, round_model('0, 4'd5));
      end
      select_i = 1'b1;
      round_i = 4'd0;
      permutation_i = iv_s;
      step();
      enable_i = 1'b0;
      total++;
      if (permutation_o !== round_model(iv_s, 4'd0)) begin
         bad++;
         $display("FAIL reload_after_reset: got %h want %h", permutation_o, round_model(iv_s, 4'd0));
      end
   endtask

   initial begin
      iv_s[0] = 64'h80400c0600000000;
      iv_s[1] = 64'h0001020304050607;
      iv_s[2] = 64'h08090a0b0c0d0e0f;
      iv_s[3] = 64'h0011223344556677;
      iv_s[4] = 64'h8899aabbccddeeff;
      test_reset();
      test_zero_round();
      test_p12();
      test_hold();
      test_const_sweep();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
